// File: rtl/frame_byte_scheduler.sv
// rtl/frame_byte_scheduler.sv - round-robin arbiter serializing 32-bit frame words onto a byte lane
//
// Ports:
//   div_8_clk, rst_n         clock, asynchronous active-low reset
//   en                       arbitration enable; an in-flight word always completes
//   req_valid, req_word      per-requester word offer, requester i at req_word[32*i +: 32]
//   req_ready                one-hot accept for the arbitration winner (combinational)
//   byte_out, byte_valid     registered byte lane, word sent MSB first
//   grant_id                 index of the last accepted requester
//   busy                     high while sending a word or holding the inter-word gap
//   drop_err                 one-cycle pulse when an accepted word lacks the 4'hA header
//   word_cnt                 wrapping count of fully sent words
module frame_byte_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          GAP_CYCLES = 2,
    parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
    input  logic                       div_8_clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [32*NUM_REQ-1:0]      req_word,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       drop_err,
    output logic [15:0]                word_cnt
);

    localparam int             IDW      = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
    localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    shift_q, shift_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           byte_valid_q, byte_valid_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0] last_q, last_d;
    logic           drop_q, drop_d;
    logic [15:0]    word_cnt_q, word_cnt_d;

    logic [IDW:0]   cand;
    logic [IDW-1:0] win;
    logic           found;
    logic [31:0]    win_word;
    logic           arb_slot;
    logic           take;

    // Round-robin search starting just above the last granted index.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    assign win_word = req_word[32*int'(win) +: 32];

    // With no gap configured, the cycle that drives the last byte also serves as the
    // arbitration slot, so consecutive words stream with no idle byte between them.
    assign arb_slot = (state_q == S_IDLE) ||
                      ((GAP_CYCLES == 0) && (state_q == S_SEND) && (byte_cnt_q == 2'd3));
    assign take     = arb_slot && en && found;

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_d       = last_q;
        drop_d       = 1'b0;
        word_cnt_d   = word_cnt_q;

        case (state_q)
            S_IDLE: begin
                byte_out_d   = IDLE_BYTE;
                byte_valid_d = 1'b0;
            end
            S_SEND: begin
                if (byte_cnt_q == 2'd3) begin
                    word_cnt_d   = word_cnt_q + 16'd1;
                    byte_out_d   = IDLE_BYTE;
                    byte_valid_d = 1'b0;
                    gap_cnt_d    = 4'd0;
                    state_d      = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else begin
                    shift_d    = shift_q << 8;
                    byte_out_d = shift_q[23:16];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_GAP: begin
                byte_out_d   = IDLE_BYTE;
                byte_valid_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                byte_out_d   = IDLE_BYTE;
                byte_valid_d = 1'b0;
            end
        endcase

        // A bad header is consumed but never reaches the lane.
        if (take) begin
            last_d = win;
            if (win_word[31:28] == 4'hA) begin
                shift_d      = win_word;
                byte_out_d   = win_word[31:24];
                byte_valid_d = 1'b1;
                byte_cnt_d   = 2'd0;
                state_d      = S_SEND;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_out_q   <= IDLE_BYTE;
            byte_valid_q <= 1'b0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            last_q       <= LAST_RST;
            drop_q       <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_q       <= last_d;
            drop_q       <= drop_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign grant_id   = last_q;
    assign busy       = (state_q != S_IDLE);
    assign drop_err   = drop_q;
    assign word_cnt   = word_cnt_q;

endmodule
